// File: rtl/uart_word_bridge.sv
`default_nettype none
// ============================================================================
// uart_word_bridge : packs UART RX bytes into words, serialises words to UART TX
// Revision 1.0
// ============================================================================
module uart_word_bridge #(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [N_BITS-1:0]    i_rx_data,
    input  logic                 i_rx_clear,
    output logic [NB_DATA-1:0]   o_word,
    output logic                 o_word_valid,
    output logic [1:0]           o_rx_count,
    input  logic                 i_word_start,
    input  logic [NB_DATA-1:0]   i_word,
    output logic                 o_tx_start,
    output logic [N_BITS-1:0]    o_tx_data,
    input  logic                 i_tx_done,
    output logic                 o_tx_busy,
    output logic                 o_word_done
);

    localparam int N_BYTES = NB_DATA / N_BITS;
    localparam int SH_W    = NB_DATA - N_BITS;
    localparam logic [1:0] LAST_IDX = 2'(N_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_t;

    logic [SH_W-1:0]    rx_shift;
    tx_state_t          tx_state;
    logic [NB_DATA-1:0] tx_buf;
    logic [1:0]         tx_idx;

    // RX packer: only the lower bytes need storing, the newest byte completes the word
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_shift     <= '0;
            o_rx_count   <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (i_rx_clear) begin
                rx_shift   <= '0;
                o_rx_count <= '0;
            end else if (i_rx_done) begin
                rx_shift <= SH_W'({rx_shift, i_rx_data});
                if (o_rx_count == LAST_IDX) begin
                    o_word       <= {rx_shift, i_rx_data};
                    o_word_valid <= 1'b1;
                    o_rx_count   <= '0;
                end else begin
                    o_rx_count <= o_rx_count + 2'd1;
                end
            end
        end
    end

    // TX serialiser. SEND spends one cycle loading the byte and one cycle with
    // o_tx_start high, except for the first byte which is loaded straight from IDLE.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_state    <= ST_IDLE;
            tx_buf      <= '0;
            tx_idx      <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_tx_busy   <= 1'b0;
            o_word_done <= 1'b0;
        end else begin
            o_word_done <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (i_word_start) begin
                        tx_buf     <= i_word;
                        tx_idx     <= LAST_IDX;
                        o_tx_data  <= i_word[NB_DATA-1 -: N_BITS];
                        o_tx_start <= 1'b1;
                        o_tx_busy  <= 1'b1;
                        tx_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (o_tx_start) begin
                        o_tx_start <= 1'b0;
                        tx_state   <= ST_WAIT;
                    end else begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= tx_buf[N_BITS*tx_idx +: N_BITS];
                    end
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (tx_idx == 2'd0) begin
                            o_word_done <= 1'b1;
                            o_tx_busy   <= 1'b0;
                            tx_state    <= ST_DONE;
                        end else begin
                            tx_idx   <= tx_idx - 2'd1;
                            tx_state <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    tx_state <= ST_IDLE;
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_word_bridge : directed self-checking bench for uart_word_bridge
// Revision 1.0
// ============================================================================
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done, rx_clear, word_start, tx_done;
    logic [7:0]  rx_data;
    logic [31:0] word_in;
    logic [31:0] word_out;
    logic        word_valid, tx_start, tx_busy, word_done;
    logic [1:0]  rx_count;
    logic [7:0]  tx_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] rx_q[$];
    int          done_cnt = 0;
    int          gap_viol = 0;
    logic        prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_word_bridge dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_rx_clear  (rx_clear),
        .o_word      (word_out),
        .o_word_valid(word_valid),
        .o_rx_count  (rx_count),
        .i_word_start(word_start),
        .i_word      (word_in),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_done   (tx_done),
        .o_tx_busy   (tx_busy),
        .o_word_done (word_done)
    );

    always @(negedge clk) begin
        if (tx_start) tx_q.push_back(tx_data);
        if (tx_start && prev_start) gap_viol++;
        prev_start = tx_start;
        if (word_valid) rx_q.push_back(word_out);
        if (word_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap, input logic [1:0] exp_cnt);
        repeat (gap) tick();
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        check("rx_count", 32'(rx_count), 32'(exp_cnt));
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!tx_start && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("tx_start_timeout", 32'(tx_start), 32'd1);
    endtask

    // Drive one word through the TX side, answering each start with tx_done
    // 10 cycles later. inject=1 re-requests and alters i_word mid-transfer.
    task automatic tx_word(input logic [31:0] w, input bit inject);
        int n;
        word_in    = w;
        word_start = 1'b1;
        tick();
        word_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            check("tx_start_latency", 32'(n), (i == 0) ? 32'd0 : 32'd1);
            check("tx_busy_span", 32'(tx_busy), 32'd1);
            if (inject && i == 1) begin
                word_in    = 32'h1111_1111;
                word_start = 1'b1;
                tick();
                word_start = 1'b0;
                word_in    = 32'h5555_5555;
                repeat (8) tick();
            end else begin
                repeat (9) tick();
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        check("word_done_pulse", 32'(word_done), 32'd1);
        check("tx_busy_clear", 32'(tx_busy), 32'd0);
        tick();
        check("word_done_single", 32'(word_done), 32'd0);
    endtask

    task automatic check_tx_bytes(input logic [31:0] w, input int base);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++)
            check("tx_byte", 32'(tx_q[base+i]), 32'(v[31-8*i -: 8]));
    endtask

    initial begin
        int base;
        int dc;
        logic [31:0] bytes;
        rst = 1'b1; rx_done = 1'b0; rx_clear = 1'b0; word_start = 1'b0;
        tx_done = 1'b0; rx_data = '0; word_in = '0;
        repeat (3) tick();
        check("rst_word", word_out, 32'h0);
        check("rst_outs", {26'd0, word_valid, tx_start, tx_busy, word_done, rx_count}, 32'h0);
        rst = 1'b0;
        tick();

        // RX word with uneven gaps
        rx_byte(8'h12, 0, 2'd1);
        rx_byte(8'h34, 3, 2'd2);
        rx_byte(8'h56, 1, 2'd3);
        rx_byte(8'h78, 5, 2'd0);
        check("rx_valid", 32'(word_valid), 32'd1);
        check("rx_word1", word_out, 32'h1234_5678);
        tick();
        check("rx_valid_pulse", 32'(word_valid), 32'd0);
        rx_byte(8'hDE, 2, 2'd1);
        rx_byte(8'hAD, 0, 2'd2);
        rx_byte(8'hBE, 4, 2'd3);
        rx_byte(8'hEF, 1, 2'd0);
        check("rx_word2", word_out, 32'hDEAD_BEEF);

        // Clear coincident with a byte discards it
        rx_byte(8'hAA, 1, 2'd1);
        rx_byte(8'hBB, 1, 2'd2);
        rx_clear = 1'b1;
        rx_byte(8'hCC, 1, 2'd0);
        rx_clear = 1'b0;
        check("rx_keep_word", word_out, 32'hDEAD_BEEF);
        rx_byte(8'h01, 2, 2'd1);
        rx_byte(8'h02, 0, 2'd2);
        rx_byte(8'h03, 1, 2'd3);
        check("rx_keep_word2", word_out, 32'hDEAD_BEEF);
        rx_byte(8'h04, 3, 2'd0);
        check("rx_word3", word_out, 32'h0102_0304);
        tick();
        check("rx_word_count", 32'(rx_q.size()), 32'd3);

        // TX word, then busy rejection
        base = tx_q.size();
        tx_word(32'hCAFE_F00D, 1'b0);
        check_tx_bytes(32'hCAFE_F00D, base);
        base = tx_q.size();
        dc = done_cnt;
        tx_word(32'hCAFE_F00D, 1'b1);
        repeat (20) tick();
        check("tx_reject_count", 32'(tx_q.size() - base), 32'd4);
        check_tx_bytes(32'hCAFE_F00D, base);
        check("tx_reject_done", 32'(done_cnt - dc), 32'd1);

        // tx_done in IDLE
        base = tx_q.size();
        for (int i = 0; i < 3; i++) begin
            tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        end
        repeat (5) tick();
        check("tx_idle_done", 32'(tx_q.size() - base), 32'd0);

        // Concurrent RX and TX with coincident done pulses
        begin
            int n;
            bytes = 32'h89AB_CDEF;
            base = tx_q.size();
            word_in = 32'h0123_4567;
            word_start = 1'b1;
            tick();
            word_start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                wait_start(n);
                repeat (9) tick();
                tx_done = 1'b1;
                rx_done = 1'b1;
                rx_data = bytes[31-8*i -: 8];
                tick();
                tx_done = 1'b0;
                rx_done = 1'b0;
            end
            check("conc_rx_valid", 32'(word_valid), 32'd1);
            check("conc_rx_word", word_out, 32'h89AB_CDEF);
            check("conc_word_done", 32'(word_done), 32'd1);
            tick();
            check_tx_bytes(32'h0123_4567, base);
        end

        // Reset with both directions mid-word
        rx_byte(8'h99, 0, 2'd1);
        rx_byte(8'h88, 0, 2'd2);
        word_in = 32'hA5A5_5A5A;
        word_start = 1'b1;
        tick();
        word_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("arst_word", word_out, 32'h0);
        check("arst_outs", {26'd0, word_valid, tx_start, tx_busy, word_done, rx_count}, 32'h0);
        check("arst_txdata", 32'(tx_data), 32'h0);
        tick();
        rst = 1'b0;
        base = tx_q.size();
        repeat (15) tick();
        check("arst_no_tx", 32'(tx_q.size() - base), 32'd0);
        rx_byte(8'h0A, 0, 2'd1);
        rx_byte(8'h0B, 1, 2'd2);
        rx_byte(8'h0C, 0, 2'd3);
        rx_byte(8'h0D, 2, 2'd0);
        check("arst_rx_word", word_out, 32'h0A0B_0C0D);
        base = tx_q.size();
        tx_word(32'h3C69_96C3, 1'b0);
        check_tx_bytes(32'h3C69_96C3, base);

        check("tx_start_gap", 32'(gap_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
